// File: rtl/seq_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_alu_if : request/response bundle between the EX stage and seq_alu      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [7:0]       status;
    logic             busy;

    modport master (
        output in_valid, control, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, hi, status, busy
    );

    modport slave (
        input  in_valid, control, a, b, shamt, out_ready,
        output in_ready, out_valid, result, hi, status, busy
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_alu : multi-cycle ALU with handshake, iterative signed mul and div     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_alu #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input wire       clk,
    input wire       reset,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] C_OP_AND  = 4'd0;
    localparam logic [3:0] C_OP_OR   = 4'd1;
    localparam logic [3:0] C_OP_ADD  = 4'd2;
    localparam logic [3:0] C_OP_DIV  = 4'd4;
    localparam logic [3:0] C_OP_MUL  = 4'd5;
    localparam logic [3:0] C_OP_SUB  = 4'd6;
    localparam logic [3:0] C_OP_SLT  = 4'd7;
    localparam logic [3:0] C_OP_SLL  = 4'd8;
    localparam logic [3:0] C_OP_SRL  = 4'd9;
    localparam logic [3:0] C_OP_XOR  = 4'd10;
    localparam logic [3:0] C_OP_NOR  = 4'd11;
    localparam logic [3:0] C_OP_SRA  = 4'd12;
    localparam logic [3:0] C_OP_ADDU = 4'd13;
    localparam logic [SHW:0] C_CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] C_CNT_ONE  = (SHW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [7:0]         status_q, status_d;

    logic               w_accept;
    logic [WIDTH:0]     w_sum, w_dif;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_is_iter_mul, w_is_div;
    logic [WIDTH-1:0]   w_res, w_hi;
    logic               w_ovf, w_carry, w_sgn, w_mis, w_div0;
    logic [7:0]         w_stat;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_acc_n, w_mul_lo_n;
    logic [2*WIDTH-1:0] w_pmag, w_prod;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_acc_n, w_div_lo_n, w_quo, w_rem;

    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_sum         = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
    assign w_dif         = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
    assign w_mag_a       = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_mag_b       = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign w_is_iter_mul = (bus.control == C_OP_MUL) && !FAST_MUL;
    assign w_is_div      = (bus.control == C_OP_DIV) && (bus.b != '0);

    generate
        if (FAST_MUL) begin : g_fast_mul
            assign w_fast_prod = $signed(bus.a) * $signed(bus.b);
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // Shift-add step: {acc, lo} is the partial product, lo starts as |b|.
    assign w_mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_acc_n = w_mul_sum[WIDTH:1];
    assign w_mul_lo_n  = {w_mul_sum[0], lo_q[WIDTH-1:1]};
    assign w_pmag      = {w_mul_acc_n, w_mul_lo_n};
    assign w_prod      = neg_q ? -w_pmag : w_pmag;

    // Restoring step: acc is the partial remainder, lo shifts dividend out and quotient in.
    assign w_div_sh    = {acc_q, lo_q[WIDTH-1]};
    assign w_div_ge    = w_div_sh >= {1'b0, opnd_q};
    assign w_div_acc_n = w_div_ge ? (w_div_sh[WIDTH-1:0] - opnd_q) : w_div_sh[WIDTH-1:0];
    assign w_div_lo_n  = {lo_q[WIDTH-2:0], w_div_ge};
    assign w_quo       = neg_q ? -w_div_lo_n : w_div_lo_n;
    assign w_rem       = rneg_q ? -w_div_acc_n : w_div_acc_n;

    always_comb begin
        w_res   = '0;
        w_hi    = '0;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        w_sgn   = 1'b0;
        w_mis   = 1'b0;
        w_div0  = 1'b0;
        case (bus.control)
            C_OP_AND:  w_res = bus.a & bus.b;
            C_OP_OR:   w_res = bus.a | bus.b;
            C_OP_XOR:  w_res = bus.a ^ bus.b;
            C_OP_NOR:  w_res = ~(bus.a | bus.b);
            C_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_mis   = (w_sum[1:0] != 2'b00);
                w_sgn   = 1'b1;
            end
            C_OP_ADDU: begin
                w_res = w_sum[WIDTH-1:0];
                w_sgn = 1'b1;
            end
            C_OP_SUB: begin
                w_res   = w_dif[WIDTH-1:0];
                w_carry = w_dif[WIDTH];
                w_sgn   = 1'b1;
            end
            C_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            C_OP_SLL:  w_res = bus.b << bus.shamt;
            C_OP_SRL:  w_res = bus.b >> bus.shamt;
            C_OP_SRA:  w_res = $signed(bus.b) >>> bus.shamt;
            C_OP_MUL: begin
                w_res = w_fast_prod[WIDTH-1:0];
                w_hi  = w_fast_prod[2*WIDTH-1:WIDTH];
                w_ovf = (w_hi != {WIDTH{w_res[WIDTH-1]}});
                w_sgn = 1'b1;
            end
            C_OP_DIV:  w_div0 = (bus.b == '0);
            default:   w_res = '0;
        endcase
        w_stat = {(w_res == '0), w_ovf, w_carry, w_sgn & w_res[WIDTH-1], w_mis, w_div0, 2'b00};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        hi_d     = hi_q;
        status_d = status_q;
        case (state_q)
            S_MUL: begin
                acc_d = w_mul_acc_n;
                lo_d  = w_mul_lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == C_CNT_ONE) begin
                    result_d = w_prod[WIDTH-1:0];
                    hi_d     = w_prod[2*WIDTH-1:WIDTH];
                    status_d = {(w_prod[WIDTH-1:0] == '0),
                                (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}}),
                                1'b0, w_prod[WIDTH-1], 4'b0000};
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = w_div_acc_n;
                lo_d  = w_div_lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == C_CNT_ONE) begin
                    result_d = w_quo;
                    hi_d     = w_rem;
                    status_d = {(w_quo == '0), 2'b00, w_quo[WIDTH-1], 4'b0000};
                    state_d  = S_DONE;
                end
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = state_q;
        endcase
        if (w_accept) begin
            if (w_is_iter_mul) begin
                state_d = S_MUL;
                cnt_d   = C_CNT_INIT;
                acc_d   = '0;
                lo_d    = w_mag_b;
                opnd_d  = w_mag_a;
                neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            end else if (w_is_div) begin
                state_d = S_DIV;
                cnt_d   = C_CNT_INIT;
                acc_d   = '0;
                lo_d    = w_mag_a;
                opnd_d  = w_mag_b;
                neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                rneg_d  = bus.a[WIDTH-1];
            end else begin
                state_d  = S_DONE;
                result_d = w_res;
                hi_d     = w_hi;
                status_d = w_stat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            status_q <= status_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.status    = status_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_alu : directed vectors against a queued scoreboard for seq_alu      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seq_alu;
    localparam int WIDTH = 32;
    localparam int TMO   = 200;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [7:0]  st;
        string       nm;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    seq_alu_if #(.WIDTH(WIDTH)) bus ();
    seq_alu #(.WIDTH(WIDTH), .FAST_MUL(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual result %0h required no output", bus.result);
                end else begin
                    e = sb_q.pop_front();
                    check({e.nm, "_result"}, bus.result, e.res);
                    check({e.nm, "_hi"},     bus.hi,     e.hi);
                    check({e.nm, "_status"}, bus.status, e.st);
                end
            end
        end
    end

    // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic [31:0] eh,
                        input logic [7:0] es, input string nm, input bit push, output int waits);
        exp_t e;
        if (push) begin
            e.res = er; e.hi = eh; e.st = es; e.nm = nm;
            sb_q.push_back(e);
        end
        bus.control  = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < TMO) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: actual in_ready 0 required 1", nm);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h1234_5678;
        bus.shamt    = 5'd13;
        bus.control  = 4'd3;
    endtask

    task automatic wait_valid(input string nm, input int req);
        int lat = 1;
        while (!bus.out_valid && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, lat, req);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic [31:0] eh,
                       input logic [7:0] es, input string nm, input int lat);
        int w;
        send(op, a, b, sh, er, eh, es, nm, 1'b1, w);
        wait_valid(nm, lat);
    endtask

    logic [3:0]  s_op  [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
    logic [31:0] s_a   [4] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h00FF};
    logic [31:0] s_b   [4] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'hFF00};
    logic [31:0] s_res [4] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'h0000};
    logic [7:0]  s_st  [4] = '{8'h00, 8'h00, 8'h00, 8'h80};

    initial begin : stim
        int w;
        bus.in_valid  = 1'b0;
        bus.control   = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_busy",      bus.busy,      0);
        check("rst_result",    bus.result,    0);
        check("rst_hi",        bus.hi,        0);
        check("rst_status",    bus.status,    0);
        @(posedge clk);
        #1;

        run(4'd2,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 32'h0,        8'h10, "add_ovf",   1);
        run(4'd2,  32'h1,        32'h2,        5'd0,  32'h3,        32'h0,        8'h08, "add_mis",   1);
        run(4'd2,  32'h80000000, 32'h80000000, 5'd0,  32'h0,        32'h0,        8'hA0, "add_carry", 1);
        run(4'd6,  32'h5,        32'h7,        5'd0,  32'hFFFFFFFE, 32'h0,        8'h30, "sub_neg",   1);
        run(4'd13, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 32'h0,        8'h10, "addu",      1);
        run(4'd7,  32'h80000000, 32'h1,        5'd0,  32'h1,        32'h0,        8'h00, "slt_min",   1);
        run(4'd7,  32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h0,        32'h0,        8'h80, "slt_max",   1);
        run(4'd8,  32'h0,        32'h1,        5'd4,  32'h10,       32'h0,        8'h00, "sll",       1);
        run(4'd9,  32'h0,        32'h80000000, 5'd31, 32'h1,        32'h0,        8'h00, "srl",       1);
        run(4'd12, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 32'h0,        8'h00, "sra",       1);
        run(4'd11, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'h0,        8'h00, "nor",       1);
        run(4'd5,  32'hFFFFFFFD, 32'h7,        5'd0,  32'hFFFFFFEB, 32'hFFFFFFFF, 8'h10, "mul_neg",  33);
        run(4'd5,  32'h00010000, 32'h00010000, 5'd0,  32'h0,        32'h1,        8'hC0, "mul_ovf",  33);
        run(4'd5,  32'h80000000, 32'h80000000, 5'd0,  32'h0,        32'h40000000, 8'hC0, "mul_min",  33);
        run(4'd4,  32'hFFFFFFF9, 32'h2,        5'd0,  32'hFFFFFFFD, 32'hFFFFFFFF, 8'h10, "div_nega", 33);
        run(4'd4,  32'h7,        32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 32'h1,        8'h10, "div_negb", 33);
        run(4'd4,  32'h5,        32'h0,        5'd0,  32'h0,        32'h0,        8'h84, "div_zero",  1);
        run(4'd4,  32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 32'h0,        8'h10, "div_min",  33);
        run(4'd3,  32'h5,        32'h5,        5'd0,  32'h0,        32'h0,        8'h80, "undef3",    1);
        run(4'd15, 32'h5,        32'h5,        5'd0,  32'h0,        32'h0,        8'h80, "undef15",   1);

        // Full-rate stream: every op must be taken on the first edge it is offered.
        for (int i = 0; i < 4; i++) begin
            send(s_op[i], s_a[i], s_b[i], 5'd0, s_res[i], 32'h0, s_st[i], "stream", 1'b1, w);
            check("stream_wait", w, 0);
            check("stream_out_valid", bus.out_valid, 1);
        end

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(4'd6, 32'hA, 32'h3, 5'd0, 32'h7, 32'h0, 8'h00, "hold_sub", 1'b1, w);
        wait_valid("hold_sub", 1);
        bus.in_valid = 1'b1;
        bus.control  = 4'd2;
        bus.a        = 32'h1;
        bus.b        = 32'h1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready",  bus.in_ready,  0);
            check("hold_result",    bus.result,    32'h7);
            check("hold_status",    bus.status,    8'h00);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(4'd4, 32'd100, 32'd7, 5'd0, 32'h0, 32'h0, 8'h00, "abort_div", 1'b0, w);
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy",      bus.busy,      0);
        check("abort_in_ready",  bus.in_ready,  1);
        check("abort_result",    bus.result,    0);
        @(posedge clk);
        #1 reset = 1'b0;
        w = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) w++;
        end
        check("abort_no_output", w, 0);

        run(4'd2, 32'h2, 32'h2, 5'd0, 32'h4, 32'h0, 8'h00, "post_reset_add", 1);
        @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
